adv_frame_writer: RTL and testbench
===================================

# adv_frame_writer

Downstream neighbour of the ADV capture input stage. It takes the packed 32-bit pixel words (two 16-bit pixels per word) that capture emits on the LLC pixel clock and buffers them in a small FIFO. It drains each word to a single-port memory write interface with an address derived from the word's position in the frame. It also tracks frame boundaries, counts completed frames, and flags overflow and short frames.

## Interface
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥4
- ADDR_W, 21, word-address width; matches the capture stage's 21-bit counter
- BASE_ADDR, 0, memory word address of word 0 of every frame
- FRAME_WORDS, 460800, words per frame (1280×720 / 2)
- LLC  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  32  packed pixel word from capture
- in_valid  in  1  one-cycle strobe per word
- in_sof  in  1  one-cycle start-of-frame pulse (VS rising); never coincident with in_valid
- mem_req  out  1  write request
- mem_addr  out  ADDR_W  word address, BASE_ADDR + word index, modulo 2^ADDR_W
- mem_wdata  out  32  write data
- mem_ack  in  1  transfer occurs on the edge where mem_req && mem_ack
- frame_done  out  1  one-cycle pulse when a full frame has been written
- frame_count  out  8  completed frames, wraps 255→0
- overflow  out  1  sticky: a word was dropped on a full FIFO
- short_frame  out  1  sticky: in_sof arrived before FRAME_WORDS words
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- FSM states: IDLE, CAPTURE, FLUSH.
- IDLE: in_valid is ignored. On in_sof: go to CAPTURE, in_idx←0.
- CAPTURE: each in_valid pushes {in_idx, in_data}, then in_idx++.
  - When in_idx reaches FRAME_WORDS−1 and is pushed (or dropped), go to FLUSH.
- FLUSH: in_valid is ignored. Once the FIFO is empty and no transfer is pending, pulse frame_done, increment frame_count, and go to IDLE.
- in_sof during CAPTURE: set short_frame, clear the FIFO, set in_idx←0, stay in CAPTURE. frame_count is unchanged.
- in_sof during FLUSH: the current frame completes normally (frame_done, count). The new SOF is held pending and taken on entry to IDLE, so the FSM goes straight to CAPTURE.
- Full FIFO plus in_valid: the word is dropped and overflow is set. in_idx still increments, so later words keep correct addresses. Fullness is judged on the pre-edge level; a pop in the same cycle does not rescue the push.
- Memory side: the FIFO head is shown ahead. mem_req = FIFO non-empty.
  - mem_addr/mem_wdata come from the head entry and stay stable while mem_req && !mem_ack.
  - On ack, the head pops and the next entry appears the following cycle; mem_req may stay high back-to-back.
- Push and pop in the same cycle: both occur and the level is unchanged.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - State IDLE, in_idx 0, FIFO empty, fifo_level 0.
  - mem_req 0, mem_addr 0, mem_wdata 0.
  - frame_done 0, frame_count 0, overflow 0, short_frame 0, SOF-pending 0.
- Latency: word strobed at edge N into an empty FIFO → mem_req high from edge N+1 with its address and data.
- Throughput: one word per LLC cycle when mem_ack is tied high.
- frame_done asserts the cycle after the final ack's edge.
- Reset mid-frame: everything returns immediately to reset values; queued words are lost.

## Structure
- Shared package adv_capture_pkg holds:
  - constants PIX_W=16, WORD_W=32, ADDR_W=21, FRAME_WORDS
  - the FSM state enum
  - the FIFO entry type {addr, data}
- One sub-module, adv_sync_fifo: single-clock, show-ahead, parameterised width and depth, with level output and a synchronous clear input.
- The FSM, index counter and flags live in the top module.

## Test plan
Bench uses FRAME_WORDS=8, FIFO_DEPTH=4, BASE_ADDR=0x100, and LLC period 40 ns.
- Nominal frame: in_sof, then 8 consecutive words 0xA0..0xA7 with mem_ack=1 → writes to 0x100..0x107 in order. frame_done pulses once, frame_count=1, both flags 0.
- Backpressure overflow: mem_ack=0 while 6 words are strobed → 4 queued, words 5–6 dropped, overflow=1. Release ack → addresses 0x100..0x103 written. Later words in the frame land at their own index addresses.
- Short frame: in_sof, 3 words, in_sof, 8 words → short_frame=1, frame_count=1. The second frame is written to 0x100..0x107.
- Stall stability: hold mem_ack=0 for 5 cycles with the FIFO non-empty → mem_addr and mem_wdata unchanged; ack then pops exactly one entry.
- IDLE filtering and reset: in_valid without in_sof → no mem_req. Assert rst_n=0 mid-CAPTURE → all outputs zero within the same cycle, fifo_level=0.
- Wrap: BASE_ADDR=2^21−4 → addresses wrap to 0x000000..0x000003.

Source files
------------

// File: rtl/adv_capture_pkg.sv
// rtl/adv_capture_pkg.sv - shared constants and types for the ADV capture/frame-writer path
//
// Contents:
//   PIX_W, WORD_W      pixel and packed-word widths
//   ADDR_W             word-address / word-index width (21 bits, shared with capture)
//   FRAME_WORDS        words per 1280x720 frame at two pixels per word
//   state_e            frame writer FSM states
//   fifo_entry_t       buffered word: {word index, packed pixel data}

package adv_capture_pkg;

   localparam int PIX_W       = 16;
   localparam int WORD_W      = 32;
   localparam int ADDR_W      = 21;
   localparam int FRAME_WORDS = 460800;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FLUSH   = 2'd2
   } state_e;

   // addr carries the word's index within the frame; the base address is
   // added on the memory side so the FIFO stays independent of placement.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/adv_sync_fifo.sv
// rtl/adv_sync_fifo.sv - single-clock show-ahead FIFO with level output and synchronous clear
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset (pointers and level only)
//   clr_i     synchronous clear; discards all entries, wins over push/pop
//   push_i    write wdata_i; ignored when full (pre-edge level)
//   wdata_i   write data
//   pop_i     discard head entry; ignored when empty
//   rdata_o   head entry, valid whenever empty_o is low
//   empty_o   no entries
//   full_o    DEPTH entries
//   level_o   current occupancy, 0..DEPTH

module adv_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Fullness is taken from the registered level, so a pop in the same
   // cycle never makes room for a push into a full FIFO.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
      end
   end

   // Storage needs no reset: entries are only observed once written.
   always_ff @(posedge clk_i) begin
      if (push_ok && !clr_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/adv_frame_writer.sv
// rtl/adv_frame_writer.sv - buffers captured pixel words and writes them to memory by frame position
//
// Ports:
//   LLC          pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      packed two-pixel word from capture
//   in_valid     one-cycle strobe per word
//   in_sof       one-cycle start-of-frame pulse (never with in_valid)
//   mem_req      write request, high while the FIFO holds a word
//   mem_addr     BASE_ADDR + word index, modulo 2^ADDR_W (0 when idle)
//   mem_wdata    write data of the head word (0 when idle)
//   mem_ack      transfer happens on an edge with mem_req && mem_ack
//   frame_done   one-cycle pulse when a whole frame has drained
//   frame_count  completed frames, wraps 255 -> 0
//   overflow     sticky, a word was dropped on a full FIFO
//   short_frame  sticky, a new SOF cut a frame short
//   fifo_level   FIFO occupancy

module adv_frame_writer #(
   parameter int                FIFO_DEPTH  = 16,
   parameter int                ADDR_W      = adv_capture_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                FRAME_WORDS = adv_capture_pkg::FRAME_WORDS
) (
   input  logic                          LLC,
   input  logic                          rst_n,
   input  logic [31:0]                   in_data,
   input  logic                          in_valid,
   input  logic                          in_sof,
   output logic                          mem_req,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [31:0]                   mem_wdata,
   input  logic                          mem_ack,
   output logic                          frame_done,
   output logic [7:0]                    frame_count,
   output logic                          overflow,
   output logic                          short_frame,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   import adv_capture_pkg::*;

   localparam int IDX_W = adv_capture_pkg::ADDR_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  in_idx_q, in_idx_d;
   logic              sof_pend_q, sof_pend_d;
   logic [7:0]        frame_count_q, frame_count_d;
   logic              overflow_q, overflow_d;
   logic              short_frame_q, short_frame_d;

   logic              fifo_push;
   logic              fifo_clr;
   logic              fifo_empty;
   logic              fifo_full;
   fifo_entry_t       push_entry;
   fifo_entry_t       head_entry;
   logic              done;

   assign push_entry.addr = in_idx_q;
   assign push_entry.data = in_data;

   adv_sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (LLC),
      .rst_ni  (rst_n),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (mem_ack),
      .rdata_o (head_entry),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (fifo_level)
   );

   // Address and data are forced to zero while nothing is queued so the
   // memory port is quiet (and reset-clean) whenever mem_req is low.
   assign mem_req   = !fifo_empty;
   assign mem_addr  = mem_req ? (BASE_ADDR + ADDR_W'(head_entry.addr)) : '0;
   assign mem_wdata = mem_req ? head_entry.data : '0;

   assign frame_done  = done;
   assign frame_count = frame_count_q;
   assign overflow    = overflow_q;
   assign short_frame = short_frame_q;

   always_ff @(posedge LLC or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         in_idx_q      <= '0;
         sof_pend_q    <= 1'b0;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
         short_frame_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_idx_q      <= in_idx_d;
         sof_pend_q    <= sof_pend_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
         short_frame_q <= short_frame_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      in_idx_d      = in_idx_q;
      sof_pend_d    = sof_pend_q;
      frame_count_d = frame_count_q;
      overflow_d    = overflow_q;
      short_frame_d = short_frame_q;
      fifo_push     = 1'b0;
      fifo_clr      = 1'b0;
      done          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_sof) begin
               state_d  = ST_CAPTURE;
               in_idx_d = '0;
            end
         end

         ST_CAPTURE: begin
            if (in_sof) begin
               // Restart: queued words of the aborted frame are discarded.
               short_frame_d = 1'b1;
               fifo_clr      = 1'b1;
               in_idx_d      = '0;
            end else if (in_valid) begin
               // The index advances even for dropped words so later words
               // still land at their own addresses.
               fifo_push = 1'b1;
               if (fifo_full) overflow_d = 1'b1;
               in_idx_d = in_idx_q + 1'b1;
               if (in_idx_q == LAST_IDX) state_d = ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            if (fifo_empty) begin
               done          = 1'b1;
               frame_count_d = frame_count_q + 8'd1;
               // A SOF seen while draining (or right now) starts the next
               // frame without passing through an idle cycle.
               if (sof_pend_q || in_sof) begin
                  state_d    = ST_CAPTURE;
                  in_idx_d   = '0;
                  sof_pend_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (in_sof) begin
               sof_pend_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_adv_frame_writer.sv
// tb/tb_adv_frame_writer.sv - self-checking bench for adv_frame_writer

module tb_adv_frame_writer;

   localparam int          FW    = 8;
   localparam int          DEPTH = 4;
   localparam logic [20:0] BASE1 = 21'h000100;
   localparam logic [20:0] BASE2 = 21'h1FFFFC;

   logic        LLC = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        mem_ack = 1'b0;

   logic        mem_req_a, mem_req_b;
   logic [20:0] mem_addr_a, mem_addr_b;
   logic [31:0] mem_wdata_a, mem_wdata_b;
   logic        frame_done_a, frame_done_b;
   logic [7:0]  frame_count_a, frame_count_b;
   logic        overflow_a, overflow_b;
   logic        short_frame_a, short_frame_b;
   logic [2:0]  fifo_level_a, fifo_level_b;

   always #20 LLC = ~LLC;

   adv_frame_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(21), .BASE_ADDR(BASE1), .FRAME_WORDS(FW)) dut_a (
      .LLC(LLC), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
      .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ack(mem_ack),
      .frame_done(frame_done_a), .frame_count(frame_count_a), .overflow(overflow_a),
      .short_frame(short_frame_a), .fifo_level(fifo_level_a));

   adv_frame_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(21), .BASE_ADDR(BASE2), .FRAME_WORDS(FW)) dut_b (
      .LLC(LLC), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
      .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ack(mem_ack),
      .frame_done(frame_done_b), .frame_count(frame_count_b), .overflow(overflow_b),
      .short_frame(short_frame_b), .fifo_level(fifo_level_b));

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 idle, 1 capturing, 2 draining.
   int          m_phase = 0;
   int          m_idx = 0;
   bit          m_pend = 0;
   bit          m_ovf = 0;
   bit          m_short = 0;
   int          m_count = 0;
   int          q_idx[$];
   logic [31:0] q_data[$];
   int          done_seen = 0;
   bit          rand_ack = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_idx = 0; m_pend = 0; m_ovf = 0; m_short = 0; m_count = 0;
      q_idx.delete(); q_data.delete();
   endtask

   // One LLC cycle: check outputs at the falling edge against the model,
   // advance the model by the rules for the coming rising edge.
   task automatic tick();
      int  sz;
      bit  xfer;
      bit  cleared;
      logic [20:0] ea, eb;
      if (rand_ack) mem_ack = 1'($urandom_range(0, 1));
      @(negedge LLC);
      sz = q_data.size();
      chk("mem_req_a", mem_req_a, sz != 0);
      chk("mem_req_b", mem_req_b, sz != 0);
      chk("fifo_level", fifo_level_a, sz);
      chk("frame_done_a", frame_done_a, (m_phase == 2) && (sz == 0));
      chk("frame_done_b", frame_done_b, (m_phase == 2) && (sz == 0));
      chk("frame_count", frame_count_a, m_count);
      chk("overflow", overflow_a, m_ovf);
      chk("short_frame", short_frame_a, m_short);
      if (sz != 0) begin
         ea = BASE1 + 21'(q_idx[0]);
         eb = BASE2 + 21'(q_idx[0]);
         chk("mem_addr_a", mem_addr_a, ea);
         chk("mem_addr_b", mem_addr_b, eb);
         chk("mem_wdata", mem_wdata_a, q_data[0]);
      end
      if (frame_done_a) done_seen++;

      xfer = (sz != 0) && mem_ack;
      cleared = 0;
      if (xfer) begin
         void'(q_idx.pop_front());
         void'(q_data.pop_front());
      end
      case (m_phase)
         0: if (in_sof) begin m_phase = 1; m_idx = 0; end
         1: begin
            if (in_sof) begin
               m_short = 1; cleared = 1; m_idx = 0;
               q_idx.delete(); q_data.delete();
            end else if (in_valid) begin
               if (sz < DEPTH) begin
                  q_idx.push_back(m_idx);
                  q_data.push_back(in_data);
               end else begin
                  m_ovf = 1;
               end
               if (m_idx == FW - 1) m_phase = 2;
               m_idx++;
            end
         end
         default: begin
            if (sz == 0) begin
               m_count = (m_count + 1) % 256;
               if (m_pend || in_sof) begin m_phase = 1; m_idx = 0; m_pend = 0; end
               else m_phase = 0;
            end else if (in_sof) begin
               m_pend = 1;
            end
         end
      endcase
      @(posedge LLC);
      #1;
   endtask

   task automatic send_sof();
      in_sof = 1'b1; tick(); in_sof = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d);
      in_valid = 1'b1; in_data = d; tick(); in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      rand_ack = 0;
      mem_ack = 1'b1;
      while (m_phase == 2 && budget < 100) begin
         tick();
         budget++;
      end
      if (budget >= 100) begin
         errors++;
         $error("FAIL drain_timeout: observed %0d cycles required < 100", budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #1;
      chk("rst_mem_req", mem_req_a, 0);
      chk("rst_mem_addr", mem_addr_a, 0);
      chk("rst_mem_wdata", mem_wdata_a, 0);
      chk("rst_level", fifo_level_a, 0);
      chk("rst_count", frame_count_a, 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Nominal frame
      mem_ack = 1'b1;
      send_sof();
      for (int i = 0; i < FW; i++) send_word(32'hA0 + 32'(i));
      wait_drain();
      idle(2);
      chk("nom_count", frame_count_a, 1);
      chk("nom_done_pulses", done_seen, 1);
      chk("nom_overflow", overflow_a, 0);
      chk("nom_short", short_frame_a, 0);

      // IDLE filtering
      for (int i = 0; i < 3; i++) send_word($urandom);
      chk("idle_no_req", mem_req_a, 0);

      // Backpressure overflow
      mem_ack = 1'b0;
      send_sof();
      for (int i = 0; i < 6; i++) send_word(32'hB0 + 32'(i));
      chk("ovf_level", fifo_level_a, 4);
      chk("ovf_flag", overflow_a, 1);
      mem_ack = 1'b1;
      idle(5);
      for (int i = 6; i < FW; i++) send_word(32'hB0 + 32'(i));
      wait_drain();
      chk("ovf_count", frame_count_a, 2);

      // Short frame
      send_sof();
      for (int i = 0; i < 3; i++) send_word(32'hC0 + 32'(i));
      send_sof();
      for (int i = 0; i < FW; i++) send_word(32'hD0 + 32'(i));
      wait_drain();
      chk("short_flag", short_frame_a, 1);
      chk("short_count", frame_count_a, 3);

      // Stall stability
      mem_ack = 1'b0;
      send_sof();
      send_word(32'hE0);
      send_word(32'hE1);
      idle(5);
      chk("stall_level", fifo_level_a, 2);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("stall_pop_one", fifo_level_a, 1);
      mem_ack = 1'b1;
      for (int i = 2; i < FW; i++) send_word(32'hE0 + 32'(i));
      wait_drain();

      // SOF while draining starts the next frame directly
      mem_ack = 1'b0;
      send_sof();
      for (int i = 0; i < FW; i++) send_word(32'hF0 + 32'(i));
      send_sof();
      wait_drain();
      chk("pend_count", frame_count_a, 5);
      mem_ack = 1'b1;
      for (int i = 0; i < FW; i++) send_word(32'h70 + 32'(i));
      wait_drain();
      chk("pend_frame_count", frame_count_a, 6);

      // Randomized frames
      for (int f = 0; f < 4; f++) begin
         rand_ack = 1;
         send_sof();
         for (int i = 0; i < FW; i++) begin
            if (f == 1 && i == 3) send_sof();
            idle($urandom_range(0, 2));
            send_word($urandom);
         end
         if (f == 1) for (int i = 3; i < FW; i++) send_word($urandom);
         wait_drain();
         idle($urandom_range(0, 2));
      end

      // Reset mid-capture
      mem_ack = 1'b0;
      send_sof();
      for (int i = 0; i < 3; i++) send_word($urandom);
      #5 rst_n = 1'b0;
      #1;
      chk("rstmid_mem_req", mem_req_a, 0);
      chk("rstmid_mem_addr", mem_addr_a, 0);
      chk("rstmid_mem_wdata", mem_wdata_a, 0);
      chk("rstmid_level", fifo_level_a, 0);
      chk("rstmid_count", frame_count_a, 0);
      chk("rstmid_overflow", overflow_a, 0);
      chk("rstmid_short", short_frame_a, 0);
      chk("rstmid_done", frame_done_a, 0);
      model_reset();
      @(posedge LLC); #1;
      idle(1);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      send_sof();
      for (int i = 0; i < FW; i++) send_word($urandom);
      wait_drain();
      idle(2);
      chk("post_rst_count", frame_count_a, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
